// File: rtl/aes_key_scheduler.sv
// Sequential AES-128 key expansion: one round key per clock, streamed with an
// index/valid strobe and accumulated into a full round-key bus.
module aes_key_scheduler #(
    parameter int unsigned NR = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [127:0]            key_in,
    input  logic                    key_load,
    output logic                    ready,
    output logic                    rk_valid,
    output logic [3:0]              rk_index,
    output logic [127:0]            rk_out,
    output logic [(NR+1)*128-1:0]   full_key,
    output logic                    keys_ready
);

    localparam int unsigned KW = 128;
    localparam int unsigned FW = (NR + 1) * KW;

    // Forward S-box, entry 0 in the most significant byte.
    localparam logic [2047:0] C_SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_EXPAND = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [10:0] idx;
        idx  = 11'd2047 - {b, 3'b000};
        sbox = C_SBOX[idx -: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        sub_word = {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    // One AES-128 key-schedule step: round key r -> round key r+1.
    function automatic logic [127:0] key_step(input logic [127:0] w, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3, t, n4, n5, n6, n7;
        w0 = w[127:96];
        w1 = w[95:64];
        w2 = w[63:32];
        w3 = w[31:0];
        t  = sub_word({w3[23:0], w3[31:24]}) ^ {rc, 24'h000000};
        n4 = w0 ^ t;
        n5 = n4 ^ w1;
        n6 = n5 ^ w2;
        n7 = n6 ^ w3;
        key_step = {n4, n5, n6, n7};
    endfunction

    state_t         r_state;
    state_t         w_state_next;
    logic           w_accept;
    logic           w_emit;
    logic           w_last;
    logic [3:0]     r_round;
    logic [7:0]     r_rcon;
    logic [127:0]   r_w;
    logic [127:0]   w_next_key;
    logic [7:0]     w_rcon_next;

    logic           r_ready;
    logic           r_rk_valid;
    logic [3:0]     r_rk_index;
    logic [127:0]   r_rk_out;
    logic [FW-1:0]  r_full_key;
    logic           r_keys_ready;

    assign w_last      = (r_round == 4'(NR));
    assign w_next_key  = key_step(r_w, r_rcon);
    assign w_rcon_next = {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1b : 8'h00);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_emit       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (key_load) begin
                    w_accept     = 1'b1;
                    w_state_next = S_EXPAND;
                end
            end
            S_EXPAND: begin
                w_emit = 1'b1;
                if (w_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (key_load) begin
                    w_accept     = 1'b1;
                    w_state_next = S_EXPAND;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Working key, round counter, rcon and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_round      <= 4'd0;
            r_rcon       <= 8'h01;
            r_w          <= '0;
            r_ready      <= 1'b1;
            r_rk_valid   <= 1'b0;
            r_rk_index   <= 4'd0;
            r_rk_out     <= '0;
            r_full_key   <= '0;
            r_keys_ready <= 1'b0;
        end else begin
            r_rk_valid <= w_emit;
            if (w_accept) begin
                r_w          <= key_in;
                r_round      <= 4'd0;
                r_rcon       <= 8'h01;
                r_ready      <= 1'b0;
                r_keys_ready <= 1'b0;
            end
            if (w_emit) begin
                r_rk_out                          <= r_w;
                r_rk_index                        <= r_round;
                r_full_key[{r_round, 7'b0} +: KW] <= r_w;
                r_w                               <= w_next_key;
                r_rcon                            <= w_rcon_next;
                r_round                           <= r_round + 4'd1;
                if (w_last) begin
                    r_ready      <= 1'b1;
                    r_keys_ready <= 1'b1;
                end
            end
        end
    end

    assign ready      = r_ready;
    assign rk_valid   = r_rk_valid;
    assign rk_index   = r_rk_index;
    assign rk_out     = r_rk_out;
    assign full_key   = r_full_key;
    assign keys_ready = r_keys_ready;

endmodule

// File: tb/tb_aes_key_scheduler.sv
// Directed bench for aes_key_scheduler using the FIPS-197 key-expansion vectors.
module tb_aes_key_scheduler;

    logic           clk;
    logic           rst;
    logic [127:0]   key_in;
    logic           key_load;
    logic           ready;
    logic           rk_valid;
    logic [3:0]     rk_index;
    logic [127:0]   rk_out;
    logic [1407:0]  full_key;
    logic           keys_ready;

    int n_tests = 0;
    int n_fail  = 0;

    // FIPS-197 A.1 schedule for 2b7e1516...
    logic [127:0] K1 [0:10] = '{
        128'h2b7e151628aed2a6abf7158809cf4f3c,
        128'ha0fafe1788542cb123a339392a6c7605,
        128'hf2c295f27a96b9435935807a7359f67f,
        128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hef44a541a8525b7fb671253bdb0bad00,
        128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'h6d88a37a110b3efddbf98641ca0093fd,
        128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'head27321b58dbad2312bf5607f8d292f,
        128'hac7766f319fadc2128d12941575c006e,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6
    };

    // FIPS-197 C.1 schedule for 00010203...
    logic [127:0] K2 [0:10] = '{
        128'h000102030405060708090a0b0c0d0e0f,
        128'hd6aa74fdd2af72fadaa678f1d6ab76fe,
        128'hb692cf0b643dbdf1be9bc5006830b3fe,
        128'hb6ff744ed2c2c9bf6c590cbf0469bf41,
        128'h47f7f7bc95353e03f96c32bcfd058dfd,
        128'h3caaa3e8a99f9deb50f3af57adf622aa,
        128'h5e390f7df7a69296a7553dc10aa31f6b,
        128'h14f9701ae35fe28c440adf4d4ea9c026,
        128'h47438735a41c65b9e016baf4aebf7ad2,
        128'h549932d1f08557681093ed9cbe2c974e,
        128'h13111d7fe3944a17f307a78b4d2b30c5
    };

    aes_key_scheduler #(.NR(10)) dut (
        .clk        (clk),
        .rst        (rst),
        .key_in     (key_in),
        .key_load   (key_load),
        .ready      (ready),
        .rk_valid   (rk_valid),
        .rk_index   (rk_index),
        .rk_out     (rk_out),
        .full_key   (full_key),
        .keys_ready (keys_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_ready"},      128'(ready),            128'd1);
        chk({tag, "_rk_valid"},   128'(rk_valid),         128'd0);
        chk({tag, "_rk_index"},   128'(rk_index),         128'd0);
        chk({tag, "_rk_out"},     rk_out,                 128'd0);
        chk({tag, "_full_zero"},  128'(full_key != '0),   128'd0);
        chk({tag, "_keys_ready"}, 128'(keys_ready),       128'd0);
    endtask

    // Load a key, then check 11 emitted rounds; optionally re-pulse key_load mid-expansion.
    task automatic run_expand(input int sel, input int pulse_at);
        logic [127:0] exp;
        logic [127:0] k0;
        k0 = (sel != 0) ? K2[0] : K1[0];
        key_in   = k0;
        key_load = 1'b1;
        tick();
        key_load = 1'b0;
        key_in   = ~k0;
        chk("acc_ready",      128'(ready),      128'd0);
        chk("acc_rk_valid",   128'(rk_valid),   128'd0);
        chk("acc_keys_ready", 128'(keys_ready), 128'd0);
        for (int r = 0; r <= 10; r++) begin
            tick();
            key_load = 1'b0;
            exp = (sel != 0) ? K2[r] : K1[r];
            chk($sformatf("r%0d_valid", r),      128'(rk_valid),           128'd1);
            chk($sformatf("r%0d_index", r),      128'(rk_index),           128'(r));
            chk($sformatf("r%0d_rk_out", r),     rk_out,                   exp);
            chk($sformatf("r%0d_slice", r),      full_key[r*128 +: 128],   exp);
            chk($sformatf("r%0d_ready", r),      128'(ready),              128'(r == 10));
            chk($sformatf("r%0d_keys_ready", r), 128'(keys_ready),         128'(r == 10));
            if (r == pulse_at) begin
                key_load = 1'b1;
                key_in   = K2[0];
            end
        end
        tick();
        chk("done_rk_valid",   128'(rk_valid),   128'd0);
        chk("done_ready",      128'(ready),      128'd1);
        chk("done_keys_ready", 128'(keys_ready), 128'd1);
        chk("done_rk_out",     rk_out,           (sel != 0) ? K2[10] : K1[10]);
        for (int r = 0; r <= 10; r++) begin
            chk($sformatf("done_slice%0d", r), full_key[r*128 +: 128],
                (sel != 0) ? K2[r] : K1[r]);
        end
    endtask

    initial begin
        rst      = 1'b1;
        key_in   = '0;
        key_load = 1'b0;
        tick();
        tick();
        check_reset_values("rst");
        rst = 1'b0;

        // Basic FIPS-197 expansion.
        run_expand(0, -1);

        // Re-pulse of key_load at round 4 must be ignored.
        run_expand(0, 4);

        // Restart from DONE with a different key; previous rk_out held until round 0.
        key_in   = K2[0];
        key_load = 1'b1;
        tick();
        key_load = 1'b0;
        chk("restart_keys_ready", 128'(keys_ready), 128'd0);
        chk("restart_rk_out_hold", rk_out, K1[10]);
        chk("restart_old_slice10", full_key[1280 +: 128], K1[10]);
        for (int r = 0; r <= 10; r++) begin
            tick();
            chk($sformatf("k2_r%0d_rk_out", r), rk_out, K2[r]);
            chk($sformatf("k2_r%0d_keys_ready", r), 128'(keys_ready), 128'(r == 10));
        end

        // Reset while round 6 is on the outputs.
        key_in   = K1[0];
        key_load = 1'b1;
        tick();
        key_load = 1'b0;
        repeat (7) tick();
        chk("abort_index", 128'(rk_index), 128'd6);
        chk("abort_rk_out", rk_out, K1[6]);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_values("abort");
        run_expand(1, -1);

        // key_load held high: 11 valid cycles then 1 idle cycle, repeating.
        key_in   = K2[0];
        key_load = 1'b1;
        tick();
        for (int c = 0; c < 30; c++) begin
            chk($sformatf("hold_c%0d_valid", c), 128'(rk_valid), 128'((c % 12) != 0));
            chk($sformatf("hold_c%0d_keys_ready", c), 128'(keys_ready), 128'((c % 12) == 11));
            if ((c % 12) != 0) begin
                chk($sformatf("hold_c%0d_rk_out", c), rk_out, K2[(c % 12) - 1]);
            end
            tick();
        end
        key_load = 1'b0;
        repeat (14) tick();
        chk("final_ready", 128'(ready), 128'd1);
        chk("final_keys_ready", 128'(keys_ready), 128'd1);
        chk("final_slice10", full_key[1280 +: 128], K2[10]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
